// File: rtl/pll_clock_monitor.sv
// PLL clock monitor: counts synchronized transitions of a divided toggle over a gate window.
// Reports frequency, lock and sticky fault. Define PLL_MON_STUCK_DETECT_EN to add a stall watchdog.
module pll_clock_monitor #(
  parameter int GATE_CYCLES    = 27000,
  parameter int EXPECTED_EDGES = 6250,
  parameter int TOLERANCE      = 25,
  parameter int LOCK_WINDOWS   = 4,
  parameter int CNT_W          = 16
`ifdef PLL_MON_STUCK_DETECT_EN
  ,
  parameter int STUCK_CYCLES   = 64
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mon_toggle,
  input  logic             clear_fault,
  output logic             freq_valid,
  output logic [CNT_W-1:0] freq_count,
  output logic             locked,
  output logic             fault
);

  localparam int GATE_W = $clog2(GATE_CYCLES + 1);
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam int DIFF_W = CNT_W + 1;
  localparam logic [DIFF_W-1:0] EXP_V = DIFF_W'(EXPECTED_EDGES);
  localparam logic [DIFF_W-1:0] TOL_V = DIFF_W'(TOLERANCE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    EVAL    = 2'd2
  } state_t;

  state_t                   state_reg, state_next;
  logic [2:0]               sync_reg, sync_next;
  logic                     edge_det;
  logic [GATE_W-1:0]        gate_reg, gate_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [GOOD_W-1:0]        good_reg, good_next;
  logic                     locked_reg, locked_next;
  logic                     fault_reg, fault_next;
  logic                     fv_reg, fv_next;
  logic [CNT_W-1:0]         fcount_reg, fcount_next;
  logic signed [DIFF_W-1:0] diff;
  logic [DIFF_W-1:0]        abs_diff;
  logic                     window_good;

`ifdef PLL_MON_STUCK_DETECT_EN
  localparam int WD_W = $clog2(STUCK_CYCLES + 1);
  logic [WD_W-1:0] wdog_reg, wdog_next;
`endif

  // Three-flop chain: two stages resolve metastability, the third gives the previous level.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = mon_toggle;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign edge_det    = sync_reg[1] ^ sync_reg[2];
  assign diff        = $signed({1'b0, cnt_reg}) - $signed(EXP_V);
  assign abs_diff    = diff[DIFF_W-1] ? -diff : diff;
  assign window_good = (abs_diff <= TOL_V);

  always_comb begin
    state_next  = state_reg;
    gate_next   = gate_reg;
    cnt_next    = cnt_reg;
    good_next   = good_reg;
    locked_next = locked_reg;
    fault_next  = clear_fault ? 1'b0 : fault_reg;
    fv_next     = 1'b0;
    fcount_next = fcount_reg;
`ifdef PLL_MON_STUCK_DETECT_EN
    wdog_next   = wdog_reg;
`endif
    if (!enable) begin
      state_next  = IDLE;
      gate_next   = '0;
      cnt_next    = '0;
      good_next   = '0;
      locked_next = 1'b0;
`ifdef PLL_MON_STUCK_DETECT_EN
      wdog_next   = '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          good_next   = '0;
          locked_next = 1'b0;
          gate_next   = '0;
          cnt_next    = '0;
          state_next  = MEASURE;
        end
        MEASURE: begin
          if (edge_det && (cnt_reg != {CNT_W{1'b1}})) cnt_next = cnt_reg + 1'b1;
          if (gate_reg == GATE_W'(GATE_CYCLES - 1)) begin
            gate_next  = '0;
            state_next = EVAL;
          end else begin
            gate_next = gate_reg + 1'b1;
          end
        end
        EVAL: begin
          // Edges in this cycle are intentionally dropped.
          fv_next     = 1'b1;
          fcount_next = cnt_reg;
          gate_next   = '0;
          cnt_next    = '0;
          state_next  = MEASURE;
          if (window_good) begin
            if (good_reg != GOOD_W'(LOCK_WINDOWS)) good_next = good_reg + 1'b1;
            locked_next = (good_reg >= GOOD_W'(LOCK_WINDOWS - 1));
          end else begin
            good_next   = '0;
            locked_next = 1'b0;
            fault_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
`ifdef PLL_MON_STUCK_DETECT_EN
      if ((state_reg == IDLE) || edge_det) wdog_next = '0;
      else if (wdog_reg != WD_W'(STUCK_CYCLES)) wdog_next = wdog_reg + 1'b1;
      // Stalled toggle: abort the window and restart measurement without reporting it.
      if ((state_reg == MEASURE) && (wdog_next == WD_W'(STUCK_CYCLES))) begin
        state_next  = MEASURE;
        gate_next   = '0;
        cnt_next    = '0;
        good_next   = '0;
        locked_next = 1'b0;
        fault_next  = 1'b1;
        wdog_next   = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sync_reg   <= '0;
      gate_reg   <= '0;
      cnt_reg    <= '0;
      good_reg   <= '0;
      locked_reg <= 1'b0;
      fault_reg  <= 1'b0;
      fv_reg     <= 1'b0;
      fcount_reg <= '0;
`ifdef PLL_MON_STUCK_DETECT_EN
      wdog_reg   <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      sync_reg   <= sync_next;
      gate_reg   <= gate_next;
      cnt_reg    <= cnt_next;
      good_reg   <= good_next;
      locked_reg <= locked_next;
      fault_reg  <= fault_next;
      fv_reg     <= fv_next;
      fcount_reg <= fcount_next;
`ifdef PLL_MON_STUCK_DETECT_EN
      wdog_reg   <= wdog_next;
`endif
    end
  end

  assign freq_valid = fv_reg;
  assign freq_count = fcount_reg;
  assign locked     = locked_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_pll_clock_monitor.sv
// Testbench for pll_clock_monitor: window-level reference model built from a log of toggle flips.
// Small parameters (100-cycle gate, 25 expected edges) keep the run short.
module tb_pll_clock_monitor;

  localparam int GATE   = 100;
  localparam int EXP_E  = 25;
  localparam int TOL    = 1;
  localparam int LOCK_W = 2;
  localparam int WIN    = GATE + 1;
  localparam int CMAX   = 255;

  logic       clk = 1'b0;
  logic       rst_n, enable, mon_toggle, clear_fault;
  logic       freq_valid, locked, fault;
  logic [7:0] freq_count;
  logic       sat_en, sat_mon, sat_fv, sat_locked, sat_fault;
  logic [3:0] sat_count;

  always #5 clk = ~clk;

  pll_clock_monitor #(
    .GATE_CYCLES(GATE), .EXPECTED_EDGES(EXP_E), .TOLERANCE(TOL), .LOCK_WINDOWS(LOCK_W), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mon_toggle(mon_toggle), .clear_fault(clear_fault),
    .freq_valid(freq_valid), .freq_count(freq_count), .locked(locked), .fault(fault)
  );

  pll_clock_monitor #(
    .GATE_CYCLES(GATE), .EXPECTED_EDGES(10), .TOLERANCE(1), .LOCK_WINDOWS(2), .CNT_W(4)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(sat_en), .mon_toggle(sat_mon), .clear_fault(1'b0),
    .freq_valid(sat_fv), .freq_count(sat_count), .locked(sat_locked), .fault(sat_fault)
  );

  int cyc, fv_seen, tog_period, next_flip, exp_fv, passed, total;
  bit tog_rand;
  int flips[$];
  int m_count, m_good;
  bit m_locked, m_fault;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (freq_valid) fv_seen++;
    if (tog_period != 0 && cyc >= next_flip) begin
      mon_toggle = ~mon_toggle;
      flips.push_back(cyc);
      next_flip = cyc + (tog_rand ? int'($urandom_range(6, 2)) : tog_period);
    end
    if (cyc % 2 == 0) sat_mon = ~sat_mon;
  endtask

  // A flip driven in cycle k shows up as a counted edge in cycle k+2;
  // the window reported in cycle v measured cycles v-WIN .. v-2.
  function automatic int model_count(int v);
    int n = 0;
    foreach (flips[i]) if (flips[i] + 2 >= v - WIN && flips[i] + 2 <= v - 2) n++;
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic model_eval(input bit clr);
    bit good;
    m_count = model_count(cyc);
    good = (m_count - EXP_E <= TOL) && (EXP_E - m_count <= TOL);
    if (good) begin
      if (m_good < LOCK_W) m_good++;
      m_locked = (m_good == LOCK_W);
      if (clr) m_fault = 1'b0;
    end else begin
      m_good   = 0;
      m_locked = 1'b0;
      m_fault  = 1'b1;
    end
  endtask

  task automatic run_to_fv(input bit clr);
    while (cyc < exp_fv - 1) tick();
    clear_fault = clr;
    tick();
    clear_fault = 1'b0;
    model_eval(clr);
    exp_fv += WIN;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++; if (freq_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", freq_valid); else passed++;
    total++; if (freq_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", freq_count); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", locked); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %0b want 0", fault); else passed++;
    total++; if (sat_count !== 4'd0) $display("FAIL reset_sat_count: got %0d want 0", sat_count); else passed++;
    rst_n  = 1'b1;
    sat_en = 1'b1;
    flips.delete();
    $display("reset cyc=%0d outputs valid=%0b count=%0d locked=%0b fault=%0b", cyc, freq_valid, freq_count, locked, fault);
  endtask

  task automatic test_nominal();
    int seen0;
    tog_period = 4; tog_rand = 1'b0;
    next_flip = cyc + 1 + int'($urandom_range(3, 0));
    enable = 1'b1;
    exp_fv = cyc + 1 + WIN;
    for (int w = 0; w < 3; w++) begin
      seen0 = fv_seen;
      run_to_fv(1'b0);
      total++; if (freq_valid !== 1'b1 || fv_seen - seen0 != 1) $display("FAIL nominal_valid w%0d: got valid=%0b pulses=%0d want 1/1", w, freq_valid, fv_seen - seen0); else passed++;
      total++; if (freq_count !== 8'(m_count)) $display("FAIL nominal_count w%0d: got %0d want %0d", w, freq_count, m_count); else passed++;
      total++; if (locked !== m_locked) $display("FAIL nominal_locked w%0d: got %0b want %0b", w, locked, m_locked); else passed++;
      total++; if (fault !== m_fault) $display("FAIL nominal_fault w%0d: got %0b want %0b", w, fault, m_fault); else passed++;
      $display("nominal window cyc=%0d count=%0d locked=%0b fault=%0b", cyc, freq_count, locked, fault);
    end
  endtask

  task automatic test_fast();
    int seen0;
    for (int w = 0; w < 5; w++) begin
      if (w == 0) begin tog_period = 3; next_flip = cyc + 3; end
      if (w == 2) begin tog_period = 4; next_flip = cyc + 4; end
      seen0 = fv_seen;
      run_to_fv(1'b0);
      total++; if (freq_valid !== 1'b1 || fv_seen - seen0 != 1) $display("FAIL fast_valid w%0d: got valid=%0b pulses=%0d want 1/1", w, freq_valid, fv_seen - seen0); else passed++;
      total++; if (freq_count !== 8'(m_count)) $display("FAIL fast_count w%0d: got %0d want %0d", w, freq_count, m_count); else passed++;
      total++; if (locked !== m_locked) $display("FAIL fast_locked w%0d: got %0b want %0b", w, locked, m_locked); else passed++;
      total++; if (fault !== m_fault) $display("FAIL fast_fault w%0d: got %0b want %0b", w, fault, m_fault); else passed++;
      $display("fast window cyc=%0d count=%0d locked=%0b fault=%0b", cyc, freq_count, locked, fault);
    end
    repeat (10) tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    m_fault = 1'b0;
    total++; if (fault !== 1'b0) $display("FAIL clear_fault: got %0b want 0", fault); else passed++;
    total++; if (locked !== m_locked) $display("FAIL clear_keeps_lock: got %0b want %0b", locked, m_locked); else passed++;
    $display("clear_fault cyc=%0d fault=%0b locked=%0b", cyc, fault, locked);
  endtask

  task automatic test_stopped();
    int seen0;
    tog_period = 0;
    for (int w = 0; w < 2; w++) begin
      seen0 = fv_seen;
      run_to_fv(w == 1);
      total++; if (freq_valid !== 1'b1 || fv_seen - seen0 != 1) $display("FAIL stopped_valid w%0d: got valid=%0b pulses=%0d want 1/1", w, freq_valid, fv_seen - seen0); else passed++;
      total++; if (freq_count !== 8'(m_count)) $display("FAIL stopped_count w%0d: got %0d want %0d", w, freq_count, m_count); else passed++;
      total++; if (locked !== m_locked) $display("FAIL stopped_locked w%0d: got %0b want %0b", w, locked, m_locked); else passed++;
      total++; if (fault !== m_fault) $display("FAIL stopped_fault w%0d: got %0b want %0b", w, fault, m_fault); else passed++;
      $display("stopped window cyc=%0d count=%0d locked=%0b fault=%0b", cyc, freq_count, locked, fault);
    end
  endtask

  task automatic test_enable_drop();
    int seen0;
    tog_period = 4; next_flip = cyc + 4;
    for (int w = 0; w < 5; w++) begin
      if (w == 3) begin
        while (cyc < exp_fv - WIN + 49) tick();
        enable = 1'b0;
        seen0 = fv_seen;
        tick();
        m_good = 0; m_locked = 1'b0;
        total++; if (locked !== 1'b0) $display("FAIL drop_locked: got %0b want 0", locked); else passed++;
        total++; if (freq_valid !== 1'b0) $display("FAIL drop_valid: got %0b want 0", freq_valid); else passed++;
        repeat (80) tick();
        total++; if (fv_seen != seen0) $display("FAIL drop_no_pulse: got %0d pulses want 0", fv_seen - seen0); else passed++;
        total++; if (freq_count !== 8'(m_count)) $display("FAIL drop_count_hold: got %0d want %0d", freq_count, m_count); else passed++;
        total++; if (fault !== m_fault) $display("FAIL drop_fault_hold: got %0b want %0b", fault, m_fault); else passed++;
        $display("enable_drop cyc=%0d locked=%0b count=%0d fault=%0b", cyc, locked, freq_count, fault);
        enable = 1'b1;
        exp_fv = cyc + 1 + WIN;
      end
      seen0 = fv_seen;
      run_to_fv(1'b0);
      total++; if (freq_valid !== 1'b1 || fv_seen - seen0 != 1) $display("FAIL drop_win_valid w%0d: got valid=%0b pulses=%0d want 1/1", w, freq_valid, fv_seen - seen0); else passed++;
      total++; if (freq_count !== 8'(m_count)) $display("FAIL drop_win_count w%0d: got %0d want %0d", w, freq_count, m_count); else passed++;
      total++; if (locked !== m_locked) $display("FAIL drop_win_locked w%0d: got %0b want %0b", w, locked, m_locked); else passed++;
      total++; if (fault !== m_fault) $display("FAIL drop_win_fault w%0d: got %0b want %0b", w, fault, m_fault); else passed++;
      $display("enable window cyc=%0d count=%0d locked=%0b fault=%0b", cyc, freq_count, locked, fault);
    end
  endtask

  task automatic test_reset_mid();
    int seen0;
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (freq_valid !== 1'b0) $display("FAIL midrst_valid: got %0b want 0", freq_valid); else passed++;
    total++; if (freq_count !== 8'd0) $display("FAIL midrst_count: got %0d want 0", freq_count); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL midrst_locked: got %0b want 0", locked); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL midrst_fault: got %0b want 0", fault); else passed++;
    $display("reset_mid cyc=%0d valid=%0b count=%0d locked=%0b fault=%0b", cyc, freq_valid, freq_count, locked, fault);
    // After reset the synchronizer restarts from 0, so a high level looks like a fresh flip.
    flips.delete();
    if (mon_toggle) flips.push_back(cyc);
    m_good = 0; m_locked = 1'b0; m_fault = 1'b0; m_count = 0;
    exp_fv = cyc + 1 + WIN;
    for (int w = 0; w < 2; w++) begin
      seen0 = fv_seen;
      run_to_fv(1'b0);
      total++; if (freq_valid !== 1'b1 || fv_seen - seen0 != 1) $display("FAIL relock_valid w%0d: got valid=%0b pulses=%0d want 1/1", w, freq_valid, fv_seen - seen0); else passed++;
      total++; if (freq_count !== 8'(m_count)) $display("FAIL relock_count w%0d: got %0d want %0d", w, freq_count, m_count); else passed++;
      total++; if (locked !== m_locked) $display("FAIL relock_locked w%0d: got %0b want %0b", w, locked, m_locked); else passed++;
      total++; if (fault !== m_fault) $display("FAIL relock_fault w%0d: got %0b want %0b", w, fault, m_fault); else passed++;
      $display("relock window cyc=%0d count=%0d locked=%0b fault=%0b", cyc, freq_count, locked, fault);
    end
  endtask

  task automatic test_random();
    int seen0;
    bit clr;
    tog_rand = 1'b1; tog_period = 4; next_flip = cyc + 2;
    for (int w = 0; w < 8; w++) begin
      clr = 1'($urandom_range(1, 0));
      seen0 = fv_seen;
      run_to_fv(clr);
      total++; if (freq_valid !== 1'b1 || fv_seen - seen0 != 1) $display("FAIL random_valid w%0d: got valid=%0b pulses=%0d want 1/1", w, freq_valid, fv_seen - seen0); else passed++;
      total++; if (freq_count !== 8'(m_count)) $display("FAIL random_count w%0d: got %0d want %0d", w, freq_count, m_count); else passed++;
      total++; if (locked !== m_locked) $display("FAIL random_locked w%0d: got %0b want %0b", w, locked, m_locked); else passed++;
      total++; if (fault !== m_fault) $display("FAIL random_fault w%0d: got %0b want %0b", w, fault, m_fault); else passed++;
      $display("random window cyc=%0d clr=%0b count=%0d locked=%0b fault=%0b", cyc, clr, freq_count, locked, fault);
    end
    tog_rand = 1'b0;
  endtask

  task automatic test_saturation();
    bit got = 1'b0;
    for (int i = 0; i < 2 * WIN + 10 && !got; i++) begin
      tick();
      if (sat_fv) got = 1'b1;
    end
    total++; if (!got) $display("FAIL sat_valid: got no pulse within %0d cycles want 1", 2 * WIN + 10); else passed++;
    total++; if (sat_count !== 4'd15) $display("FAIL sat_count: got %0d want 15", sat_count); else passed++;
    total++; if (sat_fault !== 1'b1) $display("FAIL sat_fault: got %0b want 1", sat_fault); else passed++;
    total++; if (sat_locked !== 1'b0) $display("FAIL sat_locked: got %0b want 0", sat_locked); else passed++;
    $display("saturation cyc=%0d count=%0d fault=%0b locked=%0b", cyc, sat_count, sat_fault, sat_locked);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; mon_toggle = 1'b0; clear_fault = 1'b0;
    sat_en = 1'b0; sat_mon = 1'b0;
    cyc = 0; fv_seen = 0; tog_period = 0; tog_rand = 1'b0; next_flip = 0; exp_fv = 0;
    passed = 0; total = 0;
    m_count = 0; m_good = 0; m_locked = 1'b0; m_fault = 1'b0;
    test_reset();
    test_nominal();
    test_fast();
    test_stopped();
    test_enable_drop();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
